// File: rtl/czono_pkg.sv
// Shared types and helpers for the constrained-zonotope affine-map datapath.
// Holds default sizes, the FSM state enum, the saturating narrow and the block-count helper.
package czono_pkg;

  localparam int unsigned CZ_NMAX       = 512;
  localparam int unsigned CZ_NRMAX      = 512;
  localparam int unsigned CZ_NGMAX      = 512;
  localparam int unsigned CZ_LANES      = 4;
  localparam int unsigned CZ_DATA_WIDTH = 32;
  localparam int unsigned CZ_FRAC       = 16;
  localparam int unsigned CZ_SAT_W      = 128;

  typedef logic signed [CZ_DATA_WIDTH-1:0] cz_word_t;
  typedef logic signed [CZ_SAT_W-1:0]      cz_wide_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MAC   = 3'd2,
    ST_WB    = 3'd3,
    ST_FIN   = 3'd4
  } czono_state_e;

  // Clamp a wide signed value into a dw-bit signed range; the caller keeps the low dw bits.
  function automatic cz_wide_t sat_q(input cz_wide_t v, input int unsigned dw);
    cz_wide_t hi_s;
    cz_wide_t lo_s;
    hi_s = $signed((CZ_SAT_W'(1'b1) << (dw - 32'd1)) - CZ_SAT_W'(1'b1));
    lo_s = ~hi_s;
    if (v > hi_s) begin
      return hi_s;
    end else if (v < lo_s) begin
      return lo_s;
    end else begin
      return v;
    end
  endfunction

  // Column blocks needed for [c | G]: ceil((ng+1)/lanes).
  function automatic int unsigned nb_calc(input int unsigned ng, input int unsigned lanes);
    return (ng + lanes) / lanes;
  endfunction

endpackage

// File: rtl/czono_mac_lane.sv
// One multiply-accumulate lane: full-precision signed product added into a wide accumulator.
// Clear has priority over accumulate.
module czono_mac_lane #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 73
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [2*DW-1:0] prod_s;
  logic signed [AW-1:0]   acc_r;

  assign prod_s = a_i * b_i;
  assign acc_o  = acc_r;

  // Accumulator register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_r <= '0;
    end else if (clr_i) begin
      acc_r <= '0;
    end else if (en_i) begin
      acc_r <= acc_r + AW'(prod_s);
    end
  end

endmodule

// File: rtl/czono_affine_map.sv
// Sequential affine image of a constrained zonotope: out[c|G] = R*[c|G] (+ t on the centre).
// Row-outer, block-middle, k-inner loop over LANES parallel MACs with saturating writeback.
module czono_affine_map
  import czono_pkg::*;
#(
  parameter int unsigned NMAX       = CZ_NMAX,
  parameter int unsigned NRMAX      = CZ_NRMAX,
  parameter int unsigned NGMAX      = CZ_NGMAX,
  parameter int unsigned LANES      = CZ_LANES,
  parameter int unsigned DATA_WIDTH = CZ_DATA_WIDTH,
  parameter int unsigned FRAC       = CZ_FRAC,
  parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NMAX)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic                                affine_i,
  input  logic [$clog2(NMAX+1)-1:0]           z_n_i,
  input  logic [$clog2(NGMAX+1)-1:0]          z_ng_i,
  input  logic [$clog2(NRMAX+1)-1:0]          r_nr_i,
  input  logic [$clog2(NMAX+1)-1:0]           r_nc_i,
  output logic [$clog2(NRMAX)-1:0]            r_row_o,
  output logic [$clog2(NMAX)-1:0]             r_col_o,
  input  logic [DATA_WIDTH-1:0]               r_data_i,
  output logic [$clog2(NMAX)-1:0]             z_row_o,
  output logic [$clog2(NGMAX/LANES+1)-1:0]    z_blk_o,
  input  logic [LANES*DATA_WIDTH-1:0]         z_data_i,
  output logic [$clog2(NRMAX)-1:0]            t_row_o,
  input  logic [DATA_WIDTH-1:0]               t_data_i,
  output logic                                out_we_o,
  output logic [$clog2(NRMAX)-1:0]            out_row_o,
  output logic [$clog2(NGMAX/LANES+1)-1:0]    out_blk_o,
  output logic [LANES-1:0]                    out_mask_o,
  output logic [LANES*DATA_WIDTH-1:0]         out_data_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o
);

  localparam int unsigned NW   = $clog2(NMAX+1);
  localparam int unsigned NGW  = $clog2(NGMAX+1);
  localparam int unsigned NRW  = $clog2(NRMAX+1);
  localparam int unsigned ROWW = $clog2(NRMAX);
  localparam int unsigned COLW = $clog2(NMAX);
  localparam int unsigned NBW  = $clog2(NGMAX/LANES+1) + 1;

  czono_state_e state_r, state_n_s;

  logic [NW-1:0]  n_r, nc_r, k_r;
  logic [NGW-1:0] ng_r;
  logic [NRW-1:0] nr_r, row_r;
  logic [NBW-1:0] nb_r, blk_r;
  logic           affine_r, err_r, iss_v_r;
  logic [DATA_WIDTH-1:0] t_r;

  logic dim_err_s, last_blk_s, last_row_s, done_n_s, clr_s;
  logic signed [ACC_WIDTH-1:0] acc_s [LANES];
  logic [LANES-1:0]            wb_mask_s;
  logic [LANES*DATA_WIDTH-1:0] wb_data_s;
  logic signed [ACC_WIDTH-1:0] acc_sh_s;
  cz_wide_t                    wide_s;
  int                          col_s;

  logic                        out_we_r, busy_r, done_r, err_o_r;
  logic [ROWW-1:0]             out_row_r;
  logic [NBW-2:0]              out_blk_r;
  logic [LANES-1:0]            out_mask_r;
  logic [LANES*DATA_WIDTH-1:0] out_data_r;

  assign dim_err_s  = (n_r == '0) || (nr_r == '0) || (n_r != nc_r);
  assign last_blk_s = (blk_r == nb_r - NBW'(1'b1));
  assign last_row_s = (row_r == nr_r - NRW'(1'b1));
  assign clr_s      = (state_r == ST_WB);
  // The error path spends its FIN cycle registering the verdict, so done follows it.
  assign done_n_s   = ((state_r == ST_WB) && (state_n_s == ST_FIN)) ||
                      ((state_r == ST_FIN) && err_r);

  assign r_row_o    = row_r[ROWW-1:0];
  assign r_col_o    = k_r[COLW-1:0];
  assign z_row_o    = k_r[COLW-1:0];
  assign z_blk_o    = blk_r[NBW-2:0];
  assign t_row_o    = row_r[ROWW-1:0];
  assign out_we_o   = out_we_r;
  assign out_row_o  = out_row_r;
  assign out_blk_o  = out_blk_r;
  assign out_mask_o = out_mask_r;
  assign out_data_o = out_data_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign err_o      = err_o_r;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    czono_mac_lane #(.DW(DATA_WIDTH), .AW(ACC_WIDTH)) u_lane (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr_s),
      .en_i  (iss_v_r),
      .a_i   (r_data_i),
      .b_i   (z_data_i[j*DATA_WIDTH +: DATA_WIDTH]),
      .acc_o (acc_s[j])
    );
  end

  // Next-state decode
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_i) state_n_s = ST_CHECK; else state_n_s = ST_IDLE;
      ST_CHECK: if (dim_err_s) state_n_s = ST_FIN; else state_n_s = ST_MAC;
      ST_MAC:   if (k_r == n_r) state_n_s = ST_WB; else state_n_s = ST_MAC;
      ST_WB:    if (last_blk_s && last_row_s) state_n_s = ST_FIN; else state_n_s = ST_MAC;
      ST_FIN:   state_n_s = ST_IDLE;
      default:  state_n_s = ST_IDLE;
    endcase
  end

  // State register, latched sizes and loop counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      n_r      <= '0;
      nc_r     <= '0;
      ng_r     <= '0;
      nr_r     <= '0;
      nb_r     <= '0;
      k_r      <= '0;
      row_r    <= '0;
      blk_r    <= '0;
      affine_r <= 1'b0;
      err_r    <= 1'b0;
      iss_v_r  <= 1'b0;
      t_r      <= '0;
    end else begin
      state_r <= state_n_s;
      iss_v_r <= (state_r == ST_MAC) && (k_r != n_r);
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            n_r      <= z_n_i;
            nc_r     <= r_nc_i;
            ng_r     <= z_ng_i;
            nr_r     <= r_nr_i;
            nb_r     <= NBW'(nb_calc(32'(z_ng_i), LANES));
            affine_r <= affine_i;
            err_r    <= 1'b0;
          end
        end
        ST_CHECK: begin
          err_r <= dim_err_s;
          k_r   <= '0;
          row_r <= '0;
          blk_r <= '0;
        end
        ST_MAC: begin
          if (k_r == n_r) begin
            k_r <= '0;
            t_r <= t_data_i;
          end else begin
            k_r <= k_r + NW'(1'b1);
          end
        end
        ST_WB: begin
          if (last_blk_s) begin
            blk_r <= '0;
            row_r <= row_r + NRW'(1'b1);
          end else begin
            blk_r <= blk_r + NBW'(1'b1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Writeback words: shift out the fraction, add t to the centre, clamp, mask unused columns
  always_comb begin
    wb_mask_s = '0;
    wb_data_s = '0;
    acc_sh_s  = '0;
    wide_s    = '0;
    col_s     = 0;
    for (int j = 0; j < int'(LANES); j++) begin
      acc_sh_s = acc_s[j] >>> FRAC;
      wide_s   = {{(CZ_SAT_W-ACC_WIDTH){acc_sh_s[ACC_WIDTH-1]}}, acc_sh_s};
      if ((j == 0) && (blk_r == '0) && affine_r) begin
        wide_s = wide_s + {{(CZ_SAT_W-DATA_WIDTH){t_r[DATA_WIDTH-1]}}, t_r};
      end else begin
        wide_s = wide_s;
      end
      col_s = int'(blk_r) * int'(LANES) + j;
      if (col_s <= int'(ng_r)) begin
        wb_mask_s[j] = 1'b1;
        wb_data_s[j*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sat_q(wide_s, DATA_WIDTH));
      end else begin
        wb_mask_s[j] = 1'b0;
      end
    end
  end

  // Registered writeback port and handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_we_r   <= 1'b0;
      out_row_r  <= '0;
      out_blk_r  <= '0;
      out_mask_r <= '0;
      out_data_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_o_r    <= 1'b0;
    end else begin
      out_we_r   <= (state_r == ST_WB);
      out_row_r  <= row_r[ROWW-1:0];
      out_blk_r  <= blk_r[NBW-2:0];
      out_mask_r <= (state_r == ST_WB) ? wb_mask_s : '0;
      out_data_r <= (state_r == ST_WB) ? wb_data_s : '0;
      busy_r     <= (state_n_s != ST_IDLE) && !done_n_s;
      done_r     <= done_n_s;
      err_o_r    <= (state_r == ST_FIN) && err_r;
    end
  end

endmodule
